// File: rtl/xnor_psum_binarizer_if.sv
// Handshake bundle between the PE-chain readout and the binarizer:
// psum input, threshold load, flush, and the packed activation output.
interface xnor_psum_binarizer_if #(
  parameter int PSUM_WIDTH = 4,
  parameter int ACC_WIDTH  = 6,
  parameter int PACK_WIDTH = 8
);
  logic [PSUM_WIDTH-1:0] psum_in;
  logic                  psum_valid;
  logic                  psum_ready;
  logic [ACC_WIDTH-1:0]  thr_in;
  logic                  thr_load;
  logic                  flush;
  logic [PACK_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output psum_in, psum_valid, thr_in, thr_load, flush, out_ready,
    input  psum_ready, out_data, out_valid
  );

  modport slave (
    input  psum_in, psum_valid, thr_in, thr_load, flush, out_ready,
    output psum_ready, out_data, out_valid
  );
endinterface

// File: rtl/xnor_psum_binarizer.sv
// Accumulates K_ROWS popcount partial sums per pixel, thresholds them into one
// activation bit, and packs bits LSB-first into words for a valid/ready sink.
//
// state | meaning (implied by counters, no explicit state register)
// ACCUM | row_cnt advancing within a pixel
// PACK  | bit_cnt advancing within a word
// HOLD  | out_valid && !out_ready, input stalled
module xnor_psum_binarizer #(
  parameter int PSUM_WIDTH = 4,
  parameter int K_ROWS     = 3,
  parameter int ACC_WIDTH  = 6,
  parameter int PACK_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  xnor_psum_binarizer_if.slave  bus
);
  localparam int RW = (K_ROWS > 1) ? $clog2(K_ROWS) : 1;
  localparam int BW = $clog2(PACK_WIDTH);
  localparam logic [RW-1:0] ROW_LAST = RW'(K_ROWS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(PACK_WIDTH - 1);

  logic [RW-1:0]         r_row_cnt;
  logic [BW-1:0]         r_bit_cnt;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic [ACC_WIDTH-1:0]  r_thr;
  logic [PACK_WIDTH-1:0] r_pack;
  logic [PACK_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;

  logic                  w_psum_ready;
  logic                  w_accept;
  logic                  w_flush;
  logic                  w_last_row;
  logic                  w_pixel_done;
  logic                  w_word_done;
  logic                  w_bit;
  logic [ACC_WIDTH-1:0]  w_base;
  logic [ACC_WIDTH:0]    w_sum_wide;
  logic [ACC_WIDTH-1:0]  w_sum;
  logic [PACK_WIDTH-1:0] w_pack_next;
  logic [BW-1:0]         w_bit_cnt_next;

  assign w_psum_ready = !r_out_valid || bus.out_ready;
  assign w_accept     = bus.psum_valid && w_psum_ready;
  assign w_flush      = bus.flush && w_psum_ready;
  assign w_last_row   = (r_row_cnt == ROW_LAST);
  assign w_pixel_done = w_accept && w_last_row;
  assign w_word_done  = w_pixel_done && (r_bit_cnt == BIT_LAST);

  assign bus.psum_ready = w_psum_ready;
  assign bus.out_data   = r_out_data;
  assign bus.out_valid  = r_out_valid;

  // First row of a pixel starts from zero so acc need not be cleared early.
  always_comb begin
    w_base     = (r_row_cnt == '0) ? '0 : r_acc;
    w_sum_wide = {1'b0, w_base} + (ACC_WIDTH + 1)'(bus.psum_in);
    w_sum      = w_sum_wide[ACC_WIDTH] ? '1 : w_sum_wide[ACC_WIDTH-1:0];
    w_bit      = (w_sum >= r_thr);
  end

  always_comb begin
    w_pack_next    = r_pack;
    w_bit_cnt_next = r_bit_cnt;
    if (w_pixel_done) begin
      w_pack_next[r_bit_cnt] = w_bit;
      w_bit_cnt_next         = w_word_done ? '0 : r_bit_cnt + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_row_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_acc       <= '0;
      r_thr       <= '0;
      r_pack      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (bus.thr_load) r_thr <= bus.thr_in;
      if (r_out_valid && bus.out_ready) r_out_valid <= 1'b0;

      if (w_accept) begin
        if (w_last_row) begin
          r_row_cnt <= '0;
          r_acc     <= '0;
        end else begin
          r_row_cnt <= r_row_cnt + RW'(1);
          r_acc     <= w_sum;
        end
      end

      if (w_pixel_done) begin
        r_bit_cnt <= w_bit_cnt_next;
        if (w_word_done) begin
          r_out_data  <= w_pack_next;
          r_out_valid <= 1'b1;
          r_pack      <= '0;
        end else begin
          r_pack <= w_pack_next;
        end
      end

      // Flush sees the state after any psum accepted this cycle.
      if (w_flush) begin
        r_row_cnt <= '0;
        r_acc     <= '0;
        if (w_bit_cnt_next != '0) begin
          r_out_data  <= w_pack_next;
          r_out_valid <= 1'b1;
          r_bit_cnt   <= '0;
          r_pack      <= '0;
        end
      end
    end
  end
endmodule

// File: doc/xnor_psum_binarizer.md
# xnor_psum_binarizer

Readout end of the XNOR convolution array. It sits below a PE chain and consumes that chain's popcount partial sums, one per kernel row. It accumulates K_ROWS of them per output pixel and compares the total against a loadable threshold to produce one binary activation. It packs the activation bits LSB-first into PACK_WIDTH-bit words and hands them downstream over a valid/ready handshake.

## Interface

**Parameters**
- PSUM_WIDTH, 4, width of each incoming partial sum (matches the PE chain).
- K_ROWS, 3, partial sums accumulated per output pixel (kernel height), ≥1.
- ACC_WIDTH, 6, accumulator and threshold width.
- PACK_WIDTH, 8, activation bits per output word, ≥2.

**Ports** (clock and reset first)
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-low.
- psum_in  in  PSUM_WIDTH  partial sum from the bottom of the PE chain.
- psum_valid  in  1  psum_in valid this cycle.
- psum_ready  out  1  block can accept psum_in this cycle.
- thr_in  in  ACC_WIDTH  threshold value.
- thr_load  in  1  load thr_in into the threshold register.
- flush  in  1  emit the partial word, discard the partial pixel.
- out_data  out  PACK_WIDTH  packed activations; bit 0 is the oldest pixel.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  downstream accepts out_data.

## Operation

- **Reset** (rst=0 at an edge):
  - row_cnt, bit_cnt, acc, pack_reg, thr_reg, out_data and out_valid all clear to 0.
  - psum_ready is therefore 1.
  - Reset overrides every other input in the same cycle.
- **Handshake**
  - psum_ready = !out_valid || out_ready (combinational).
  - A partial sum is accepted on an edge where psum_valid && psum_ready.
- **Threshold**
  - thr_load=1 sets thr_reg <= thr_in.
  - The new value applies to comparisons from the next cycle onward.
  - thr_load is independent of the handshake.
- **Accumulation** (per accepted psum)
  - sum = (row_cnt==0 ? 0 : acc) + psum_in, computed at ACC_WIDTH+1 bits.
  - sum saturates to 2^ACC_WIDTH-1.
  - If row_cnt < K_ROWS-1: acc <= sum, row_cnt++.
  - If row_cnt == K_ROWS-1:
    - bit = (sum >= thr_reg), unsigned.
    - pack_reg[bit_cnt] <= bit; row_cnt <= 0; acc <= 0.
- **Word completion**
  - Occurs when a bit is written at bit_cnt == PACK_WIDTH-1.
  - out_data <= the completed word; out_valid <= 1; pack_reg <= 0; bit_cnt <= 0.
  - Otherwise bit_cnt++.
- **Output drain**
  - out_valid && out_ready with no completion in the same cycle: out_valid <= 0.
  - With a completion in the same cycle: out_data is replaced and out_valid stays 1 (no bubble).
- **Flush** (acted on only when psum_ready=1)
  - Any psum accepted in the same cycle is processed first.
  - The partial pixel is then discarded: row_cnt <= 0, acc <= 0.
  - If bit_cnt > 0 after that psum: out_data <= pack_reg with the upper bits zero; out_valid <= 1; bit_cnt <= 0; pack_reg <= 0.
  - If bit_cnt == 0 (including a word that completed the same cycle), flush emits nothing extra.
  - flush with psum_ready=0 is ignored; the source must hold it.
- **Control states** are implied by (row_cnt, bit_cnt, out_valid):
  - ACCUM: row_cnt advancing.
  - PACK: bit_cnt advancing.
  - HOLD: out_valid=1 && !out_ready, which stalls input.

## Timing

- Latency: out_valid rises on the same edge that accepts the final psum of the PACK_WIDTH-th pixel (registered, zero extra cycles). It is visible the following cycle.
- Throughput: one psum per cycle while out_ready=1 continuously.
- Backpressure:
  - While out_valid=1 and out_ready=0, psum_ready=0.
  - acc, row_cnt, bit_cnt and out_data hold.
  - out_data is stable until accepted.
- Rising-edge rule: out_valid falls only after a cycle with out_ready=1.
- Threshold edge case: a thr_load and a pixel completion on the same edge compare against the old thr_reg.
- Reset mid-word or mid-pixel drops all partial data; no word is emitted.
- Saturation: with the defaults, the maximum sum (45) fits in 6 bits. Saturation matters only for narrower ACC_WIDTH.

## Test plan

- **Basic threshold.** Defaults, thr=5. Pixel psums 1,2,2 (sum 5) and 1,1,2 (sum 4) alternate for 8 pixels, out_ready=1 -> one word out_data=8'b01010101, out_valid high for 1 cycle, psum_ready never low.
- **Back-to-back words.** 16 pixels, all psums 15, thr=45 -> two consecutive words of 8'hFF with no idle cycle between them.
- **Backpressure.** Complete a word, hold out_ready=0 for 5 cycles while psum_valid=1 -> psum_ready=0, out_data stable for 5 cycles, no psum lost; after out_ready=1 the next word is correct.
- **Flush.** Pixels giving bits 1,1,0, plus one extra psum (partial pixel), then flush -> out_data=8'b00000011. The next pixel lands in bit 0 with a fresh accumulator.
- **Saturation and threshold load.** ACC_WIDTH=5, three psums of 15 (sum 45 -> 31), thr loaded to 31 on the same edge as the completion, old thr_reg=0 -> bit 1. Repeat with thr=31 already active -> bit 1; with psums 15,15,0 (sum 30) -> bit 0.
- **Reset mid-operation.** Assert rst=0 after 3 pixels and 2 psums -> all outputs 0 and psum_ready=1 the next cycle. A subsequent 8-pixel sequence produces exactly one word containing only the new bits.
